// File: rtl/psec6_ch_state_ctrl.sv
// PSEC6 per-channel sampling sequencer: start/trigger/readout/clear state machine
// with SCA bank enable decode. Optional macro: PSEC6_AUTO_READOUT_EN.
module psec6_ch_state_ctrl #(
  parameter int TRIG_W = 8,
  parameter int DLY_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [1:0]        bank_sel_i,
  input  logic              slow_sel_i,
  input  logic [DLY_W-1:0]  dly_i,
  input  logic              trig_i,
  input  logic              rd_req_i,
  input  logic              rd_done_i,
  input  logic              clear_i,
  output logic [3:0]        state_o,
  output logic [4:0]        sca_en_o,
  output logic              cnt_run_o,
  output logic              cnt_clr_o,
  output logic              load_o,
  output logic [TRIG_W-1:0] trig_cnt_o,
  output logic              err_o,
  output logic              busy_o
);

  typedef enum logic [3:0] {
    STATE_INIT           = 4'd0,
    STATE_STOPPED        = 4'd1,
    STATE_SAMPLING_A     = 4'd2,
    STATE_SAMPLING_B     = 4'd3,
    STATE_SAMPLING_C     = 4'd4,
    STATE_SAMPLING_D     = 4'd5,
    STATE_SAMPLING_E     = 4'd6,
    STATE_SAMPLING_A_B   = 4'd7,
    STATE_SAMPLING_C_D   = 4'd8,
    STATE_SAMPLING_ALL   = 4'd9,
    STATE_READOUT        = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    SAMPLE1     = 2'b00,
    SAMPLE2     = 2'b01,
    SAMPLE_RSVD = 2'b10,
    SAMPLE4     = 2'b11
  } smode_t;

  state_t             state, state_nxt, start_state;
  logic [TRIG_W-1:0]  trig_cnt, trig_nxt;
  logic [DLY_W-1:0]   dly_cnt, dly_nxt;
  logic               armed, armed_nxt;
  logic               err, err_nxt;
  logic               load, load_nxt;
  logic               start_bad;
  smode_t             mode;

  assign mode      = smode_t'(mode_i);
  assign start_bad = !slow_sel_i && (mode == SAMPLE_RSVD);

  // Target sampling state for a start command; slow select overrides the mode.
  always_comb begin
    start_state = STATE_SAMPLING_ALL;
    if (slow_sel_i) start_state = STATE_SAMPLING_E;
    else begin
      case (mode)
        SAMPLE1: begin
          case (bank_sel_i)
            2'd0:    start_state = STATE_SAMPLING_A;
            2'd1:    start_state = STATE_SAMPLING_B;
            2'd2:    start_state = STATE_SAMPLING_C;
            default: start_state = STATE_SAMPLING_D;
          endcase
        end
        SAMPLE2: start_state = bank_sel_i[1] ? STATE_SAMPLING_C_D : STATE_SAMPLING_A_B;
        default: start_state = STATE_SAMPLING_ALL;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    trig_nxt  = trig_cnt;
    dly_nxt   = dly_cnt;
    armed_nxt = armed;
    err_nxt   = err;
    if (clear_i) begin
      state_nxt = STATE_INIT;
      trig_nxt  = '0;
      dly_nxt   = '0;
      armed_nxt = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        STATE_INIT, STATE_STOPPED: begin
          if (start_i) begin
            if (start_bad) err_nxt = 1'b1;
            else           state_nxt = start_state;
          end else if (rd_req_i && state == STATE_STOPPED) begin
            state_nxt = STATE_READOUT;
          end
        end
        STATE_SAMPLING_A, STATE_SAMPLING_B, STATE_SAMPLING_C, STATE_SAMPLING_D,
        STATE_SAMPLING_E, STATE_SAMPLING_A_B, STATE_SAMPLING_C_D, STATE_SAMPLING_ALL: begin
          if (trig_i && !(&trig_cnt)) trig_nxt = trig_cnt + TRIG_W'(1);
          // Only the first trigger arms the stop delay; later ones just count.
          if (armed) begin
            if (dly_cnt == '0) begin
              armed_nxt = 1'b0;
`ifdef PSEC6_AUTO_READOUT_EN
              state_nxt = STATE_READOUT;
`else
              state_nxt = STATE_STOPPED;
`endif
            end else begin
              dly_nxt = dly_cnt - DLY_W'(1);
            end
          end else if (trig_i) begin
            armed_nxt = 1'b1;
            dly_nxt   = dly_i;
          end
        end
        STATE_READOUT: begin
          if (rd_done_i && !load) state_nxt = STATE_STOPPED;
        end
        default: begin
          state_nxt = STATE_INIT;
          armed_nxt = 1'b0;
        end
      endcase
    end
    load_nxt = (state_nxt == STATE_READOUT) && (state != STATE_READOUT);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= STATE_INIT;
      trig_cnt <= '0;
      dly_cnt  <= '0;
      armed    <= 1'b0;
      err      <= 1'b0;
      load     <= 1'b0;
    end else begin
      state    <= state_nxt;
      trig_cnt <= trig_nxt;
      dly_cnt  <= dly_nxt;
      armed    <= armed_nxt;
      err      <= err_nxt;
      load     <= load_nxt;
    end
  end

  always_comb begin
    sca_en_o  = 5'b00000;
    cnt_run_o = 1'b0;
    case (state)
      STATE_SAMPLING_A:   sca_en_o = 5'b00001;
      STATE_SAMPLING_B:   sca_en_o = 5'b00010;
      STATE_SAMPLING_C:   sca_en_o = 5'b00100;
      STATE_SAMPLING_D:   sca_en_o = 5'b01000;
      STATE_SAMPLING_E:   sca_en_o = 5'b10000;
      STATE_SAMPLING_A_B: sca_en_o = 5'b00011;
      STATE_SAMPLING_C_D: sca_en_o = 5'b01100;
      STATE_SAMPLING_ALL: sca_en_o = 5'b01111;
      default:            sca_en_o = 5'b00000;
    endcase
    cnt_run_o = (state >= STATE_SAMPLING_A) && (state <= STATE_SAMPLING_ALL);
  end

  assign state_o    = state;
  assign cnt_clr_o  = (state == STATE_INIT);
  assign busy_o     = cnt_run_o || (state == STATE_READOUT);
  assign load_o     = load;
  assign trig_cnt_o = trig_cnt;
  assign err_o      = err;

endmodule

// File: tb/tb_psec6_ch_state_ctrl.sv
// Directed bench for psec6_ch_state_ctrl: vector table plus multi-cycle sequences.
module tb_psec6_ch_state_ctrl;
  localparam int TW = 8;
  localparam int DW = 8;

  localparam logic [3:0] S_INIT = 4'd0, S_STOP = 4'd1, S_A = 4'd2, S_B = 4'd3,
                         S_C = 4'd4, S_D = 4'd5, S_E = 4'd6, S_AB = 4'd7,
                         S_CD = 4'd8, S_ALL = 4'd9, S_RD = 4'd10;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start_i, slow_sel_i, trig_i, rd_req_i, rd_done_i, clear_i;
  logic [1:0]    mode_i, bank_sel_i;
  logic [DW-1:0] dly_i;
  logic [3:0]    state_o;
  logic [4:0]    sca_en_o;
  logic          cnt_run_o, cnt_clr_o, load_o, err_o, busy_o;
  logic [TW-1:0] trig_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psec6_ch_state_ctrl #(.TRIG_W(TW), .DLY_W(DW)) dut (
    .clk(clk), .rstb(rstb), .start_i(start_i), .mode_i(mode_i),
    .bank_sel_i(bank_sel_i), .slow_sel_i(slow_sel_i), .dly_i(dly_i),
    .trig_i(trig_i), .rd_req_i(rd_req_i), .rd_done_i(rd_done_i),
    .clear_i(clear_i), .state_o(state_o), .sca_en_o(sca_en_o),
    .cnt_run_o(cnt_run_o), .cnt_clr_o(cnt_clr_o), .load_o(load_o),
    .trig_cnt_o(trig_cnt_o), .err_o(err_o), .busy_o(busy_o)
  );

  typedef struct {
    logic       start;
    logic [1:0] mode;
    logic [1:0] bank;
    logic       slow;
    logic       rd_req;
    logic       clear;
    logic [3:0] st;
    logic [4:0] sca;
    logic       run;
    logic       clr;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic s, input logic [1:0] m, input logic [1:0] b,
                             input logic sl, input logic rq, input logic cl,
                             input logic [3:0] st, input logic [4:0] sca,
                             input logic run, input logic clr, input logic err,
                             input logic busy);
    vec_t r;
    r.start = s; r.mode = m; r.bank = b; r.slow = sl; r.rd_req = rq; r.clear = cl;
    r.st = st; r.sca = sca; r.run = run; r.clr = clr; r.err = err; r.busy = busy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] st, input logic [4:0] sca,
                     input logic run, input logic clr, input logic load,
                     input logic [TW-1:0] tc, input logic err, input logic busy);
    logic [21:0] a, e;
    a = {state_o, sca_en_o, cnt_run_o, cnt_clr_o, load_o, trig_cnt_o, err_o, busy_o};
    e = {st, sca, run, clr, load, tc, err, busy};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d sca=%b run=%b clr=%b load=%b tc=%0d err=%b busy=%b, want st=%0d sca=%b run=%b clr=%b load=%b tc=%0d err=%b busy=%b",
               nm, state_o, sca_en_o, cnt_run_o, cnt_clr_o, load_o, trig_cnt_o, err_o, busy_o,
               st, sca, run, clr, load, tc, err, busy);
    end
  endtask

  task automatic idle();
    start_i = 0; mode_i = 0; bank_sel_i = 0; slow_sel_i = 0;
    trig_i = 0; rd_req_i = 0; rd_done_i = 0; clear_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]    st_exp;
    logic [TW-1:0] tc_exp;
    int            tot;

    // inputs: start mode bank slow rd_req clear | state sca run clr err busy
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 0, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b00, 2'd2, 0, 0, 0, S_C,    5'b00100, 1, 0, 0, 1));
    tbl.push_back(v(1, 2'b00, 2'd0, 0, 0, 0, S_C,    5'b00100, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 1, 0, S_C,    5'b00100, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b00, 2'd0, 0, 0, 0, S_A,    5'b00001, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b00, 2'd1, 0, 0, 0, S_B,    5'b00010, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b00, 2'd3, 0, 0, 0, S_D,    5'b01000, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b01, 2'd0, 0, 0, 0, S_AB,   5'b00011, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b01, 2'd2, 0, 0, 0, S_CD,   5'b01100, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b01, 2'd1, 0, 0, 0, S_AB,   5'b00011, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b11, 2'd0, 0, 0, 0, S_ALL,  5'b01111, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b10, 2'd0, 1, 0, 0, S_E,    5'b10000, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b00, 2'd1, 1, 0, 0, S_E,    5'b10000, 1, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(1, 2'b10, 2'd0, 0, 0, 0, S_INIT, 5'b00000, 0, 1, 1, 0));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 0, S_INIT, 5'b00000, 0, 1, 1, 0));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 0, 1, S_INIT, 5'b00000, 0, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 2'd0, 0, 1, 0, S_INIT, 5'b00000, 0, 1, 0, 0));

    idle(); dly_i = '0; rstb = 1'b0;
    #12;
    chk("reset", S_INIT, 5'b00000, 0, 1, 0, 0, 0, 0);
    rstb = 1'b1;

    foreach (tbl[i]) begin
      start_i = tbl[i].start; mode_i = tbl[i].mode; bank_sel_i = tbl[i].bank;
      slow_sel_i = tbl[i].slow; rd_req_i = tbl[i].rd_req; clear_i = tbl[i].clear;
      tick(); idle();
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].sca, tbl[i].run, tbl[i].clr, 0, 0,
          tbl[i].err, tbl[i].busy);
    end

    // Trigger with dly=3, second trigger two cycles later must not reload.
    start_i = 1; mode_i = 2'b11; tick(); idle();
    chk("all_entry", S_ALL, 5'b01111, 1, 0, 0, 0, 0, 1);
    trig_i = 1; dly_i = 8'd3; tick(); idle();
    chk("trig1", S_ALL, 5'b01111, 1, 0, 0, 1, 0, 1);
    tick();
    chk("trig_wait", S_ALL, 5'b01111, 1, 0, 0, 1, 0, 1);
    trig_i = 1; dly_i = 8'd0; tick(); idle();
    chk("trig2", S_ALL, 5'b01111, 1, 0, 0, 2, 0, 1);
    tick();
    chk("edge3", S_ALL, 5'b01111, 1, 0, 0, 2, 0, 1);
    tick();
`ifdef PSEC6_AUTO_READOUT_EN
    chk("expiry_auto", S_RD, 5'b00000, 0, 0, 1, 2, 0, 1);
`else
    chk("expiry_stop", S_STOP, 5'b00000, 0, 0, 0, 2, 0, 0);
    rd_req_i = 1; tick(); idle();
    chk("rd_entry", S_RD, 5'b00000, 0, 0, 1, 2, 0, 1);
`endif
    rd_done_i = 1; tick(); idle();
    chk("rd_done_on_load", S_RD, 5'b00000, 0, 0, 0, 2, 0, 1);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rd_wait", S_RD, 5'b00000, 0, 0, 0, 2, 0, 1);
    end
    rd_done_i = 1; tick(); idle();
    chk("rd_exit", S_STOP, 5'b00000, 0, 0, 0, 2, 0, 0);

    // start beats rd_req in STOPPED; dly=0 stops one edge after the trigger
    start_i = 1; mode_i = 2'b00; bank_sel_i = 2'd0; rd_req_i = 1; tick(); idle();
    chk("start_beats_rd", S_A, 5'b00001, 1, 0, 0, 2, 0, 1);
    trig_i = 1; dly_i = 8'd0; tick(); idle();
    chk("dly0_arm", S_A, 5'b00001, 1, 0, 0, 3, 0, 1);
    tick();
`ifdef PSEC6_AUTO_READOUT_EN
    chk("dly0_expiry", S_RD, 5'b00000, 0, 0, 1, 3, 0, 1);
    tick(); rd_done_i = 1; tick(); idle();
`else
    chk("dly0_expiry", S_STOP, 5'b00000, 0, 0, 0, 3, 0, 0);
`endif
    start_i = 1; mode_i = 2'b10; tick(); idle();
    chk("bad_start_stopped", S_STOP, 5'b00000, 0, 0, 0, 3, 1, 0);
    clear_i = 1; tick(); idle();
    chk("clear_stopped", S_INIT, 5'b00000, 0, 1, 0, 0, 0, 0);

    // clear on the load cycle aborts readout
    start_i = 1; mode_i = 2'b11; tick(); idle();
    trig_i = 1; dly_i = 8'd0; tick(); idle();
    tick();
`ifndef PSEC6_AUTO_READOUT_EN
    rd_req_i = 1; tick(); idle();
`endif
    chk("load_cycle", S_RD, 5'b00000, 0, 0, 1, 1, 0, 1);
    clear_i = 1; tick(); idle();
    chk("clear_on_load", S_INIT, 5'b00000, 0, 1, 0, 0, 0, 0);

    // async reset mid A_AND_B, armed flag must be dropped too
    start_i = 1; mode_i = 2'b01; bank_sel_i = 2'd0; tick(); idle();
    chk("ab_entry", S_AB, 5'b00011, 1, 0, 0, 0, 0, 1);
    trig_i = 1; dly_i = 8'd5; tick(); idle();
    chk("ab_trig", S_AB, 5'b00011, 1, 0, 0, 1, 0, 1);
    @(negedge clk); rstb = 1'b0; #1;
    chk("async_reset", S_INIT, 5'b00000, 0, 1, 0, 0, 0, 0);
    @(negedge clk); rstb = 1'b1;
    start_i = 1; mode_i = 2'b00; bank_sel_i = 2'd1; tick(); idle();
    repeat (8) tick();
    chk("armed_reset", S_B, 5'b00010, 1, 0, 0, 0, 0, 1);
    clear_i = 1; tick(); idle();

    // saturation: 101 counted triggers per round, three rounds
    tot = 0;
    for (int r = 0; r < 3; r++) begin
      start_i = 1; mode_i = 2'b11; tick(); idle();
      trig_i = 1; dly_i = 8'd99;
      repeat (101) tick();
      idle();
      tot = tot + 101;
      tc_exp = (tot > 255) ? 8'd255 : TW'(tot);
`ifdef PSEC6_AUTO_READOUT_EN
      st_exp = S_RD;
      chk("sat_round", st_exp, 5'b00000, 0, 0, 1, tc_exp, 0, 1);
      tick(); rd_done_i = 1; tick(); idle();
`else
      st_exp = S_STOP;
      chk("sat_round", st_exp, 5'b00000, 0, 0, 0, tc_exp, 0, 0);
`endif
    end
    clear_i = 1; tick(); idle();
    chk("sat_clear", S_INIT, 5'b00000, 0, 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
